regfile_access_arbiter: RTL and testbench

- Owns the write port of the 32x32 register file and shares it between the pipeline write-back stage and a debug access port.
- Also lends one read port to the debug port.
- After reset it sequences a clear of every register, with the pipeline stalled, before normal operation starts.
- Sits between the WB stage, the debug unit and the register file. Hazard logic keeps seeing plain WB signals.

---
 rtl/regfile_access_arbiter_if.sv | 36 +++
 rtl/regfile_access_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_access_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_access_arbiter_if.sv
// Bundle of WB, debug-port and register-file signals around the regfile write-port arbiter.
// The master modport is the arbiter. The slave modport is the surrounding pipeline, debug unit and register file.
interface regfile_access_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              dbg_rd_sel;
    logic [DATA_W-1:0] rf_rdata;
    logic              pipe_stall;
    logic              init_busy;

    modport master (
        input  wb_we, wb_addr, wb_data, dbg_req, dbg_we, dbg_addr, dbg_wdata, rf_rdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata, rf_we, rf_waddr, rf_wdata,
               dbg_rd_sel, pipe_stall, init_busy
    );

    modport slave (
        output wb_we, wb_addr, wb_data, dbg_req, dbg_we, dbg_addr, dbg_wdata, rf_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, rf_we, rf_waddr, rf_wdata,
               dbg_rd_sel, pipe_stall, init_busy
    );
endinterface

// File: rtl/regfile_access_arbiter.sv
// Shares the register-file write port between WB and the debug port, lends read port 1 to debug,
// and clears every register after reset while holding the pipeline stalled.
module regfile_access_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    regfile_access_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_FORCE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] init_ptr, init_ptr_nx;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nx;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              gnt, rd_sel, stall, busy, rd_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_INIT;
            init_ptr <= '0;
            wait_cnt <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state    <= state_nx;
            init_ptr <= init_ptr_nx;
            wait_cnt <= wait_cnt_nx;
            rvalid_q <= rd_grant;
            // Sampled before the RF's own write at this edge, so a same-cycle WB write is not seen.
            if (rd_grant)
                rdata_q <= (bus.dbg_addr == '0) ? '0 : bus.rf_rdata;
        end
    end

    always_comb begin
        state_nx    = state;
        init_ptr_nx = init_ptr;
        wait_cnt_nx = wait_cnt;
        sel_we      = bus.wb_we;
        sel_addr    = bus.wb_addr;
        sel_data    = bus.wb_data;
        gnt         = 1'b0;
        rd_sel      = 1'b0;
        stall       = 1'b0;
        busy        = 1'b0;
        rd_grant    = 1'b0;
        case (state)
            S_INIT: begin
                sel_we      = 1'b1;
                sel_addr    = init_ptr;
                sel_data    = '0;
                stall       = 1'b1;
                busy        = 1'b1;
                wait_cnt_nx = '0;
                init_ptr_nx = init_ptr + 1'b1;
                if (init_ptr == ADDR_W'(NUM_REGS - 1))
                    state_nx = S_IDLE;
            end
            S_IDLE: begin
                if (!bus.dbg_req) begin
                    wait_cnt_nx = '0;
                end else if (!bus.dbg_we) begin
                    gnt         = 1'b1;
                    rd_sel      = 1'b1;
                    stall       = 1'b1;
                    rd_grant    = 1'b1;
                    wait_cnt_nx = '0;
                end else if (!bus.wb_we) begin
                    gnt         = 1'b1;
                    sel_we      = 1'b1;
                    sel_addr    = bus.dbg_addr;
                    sel_data    = bus.dbg_wdata;
                    wait_cnt_nx = '0;
                end else begin
                    // The losing cycle that brings the count to MAX_WAIT also enters FORCE.
                    wait_cnt_nx = wait_cnt + 1'b1;
                    if (wait_cnt == CNT_W'(MAX_WAIT - 1))
                        state_nx = S_FORCE;
                end
            end
            S_FORCE: begin
                stall = 1'b1;
                if (!(bus.dbg_req && bus.dbg_we)) begin
                    state_nx    = S_IDLE;
                    wait_cnt_nx = '0;
                end else if (!bus.wb_we) begin
                    gnt         = 1'b1;
                    sel_we      = 1'b1;
                    sel_addr    = bus.dbg_addr;
                    sel_data    = bus.dbg_wdata;
                    state_nx    = S_IDLE;
                    wait_cnt_nx = '0;
                end
            end
            default: state_nx = S_INIT;
        endcase
    end

    assign bus.rf_we      = sel_we && (sel_addr != '0);
    assign bus.rf_waddr   = sel_addr;
    assign bus.rf_wdata   = sel_data;
    assign bus.dbg_gnt    = gnt;
    assign bus.dbg_rd_sel = rd_sel;
    assign bus.pipe_stall = stall;
    assign bus.init_busy  = busy;
    assign bus.dbg_rvalid = rvalid_q;
    assign bus.dbg_rdata  = rdata_q;
endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench for regfile_access_arbiter: a behavioural model checks every cycle, literals pin key points.
module tb_regfile_access_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;
    localparam int MW = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_access_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_access_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .MAX_WAIT(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file behind the arbiter, preloaded with junk so the clear is observable.
    logic [DW-1:0] rfmem [NR];
    logic          rf_loaded = 1'b0;
    always @(posedge clk) begin
        if (!rf_loaded) begin
            for (int i = 0; i < NR; i++) rfmem[i] <= 32'hDEAD_0000 | 32'(i);
            rf_loaded <= 1'b1;
        end else if (bus.rf_we) begin
            rfmem[bus.rf_waddr] <= bus.rf_wdata;
        end
    end
    assign bus.rf_rdata = rfmem[bus.dbg_rd_sel ? bus.dbg_addr : AW'(0)];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: cycles of clear done, consecutive lost cycles of a pending debug write, expected RF contents.
    int            init_cnt = 0;
    int            lost = 0;
    bit            rd_pend = 0;
    logic [DW-1:0] rd_exp;
    logic [DW-1:0] mrf [NR];

    always @(negedge clk) begin : model
        logic          ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        bit            egnt, esel, estall, ebusy, rdg;
        if (rst) begin
            init_cnt = 0;
            lost     = 0;
            rd_pend  = 0;
            chk("rst_busy", bus.init_busy, 1);
            chk("rst_stall", bus.pipe_stall, 1);
            chk("rst_gnt", bus.dbg_gnt, 0);
            chk("rst_rdsel", bus.dbg_rd_sel, 0);
            chk("rst_rvalid", bus.dbg_rvalid, 0);
            chk("rst_rdata", bus.dbg_rdata, 0);
        end else begin
            chk("m_rvalid", bus.dbg_rvalid, 32'(rd_pend));
            if (rd_pend) chk("m_rdata", bus.dbg_rdata, rd_exp);
            rdg = 0; egnt = 0; esel = 0;
            if (init_cnt < NR) begin
                ebusy = 1; estall = 1; ewe = 1; ea = AW'(init_cnt); ed = '0;
                init_cnt++;
            end else begin
                ebusy  = 0;
                estall = (lost >= MW);
                ewe = bus.wb_we; ea = bus.wb_addr; ed = bus.wb_data;
                if (!bus.dbg_req) begin
                    lost = 0;
                end else if (!bus.dbg_we) begin
                    if (lost < MW) begin
                        egnt = 1; esel = 1; estall = 1; rdg = 1;
                        rd_exp = (bus.dbg_addr == 0) ? '0 : mrf[bus.dbg_addr];
                    end
                    lost = 0;
                end else if (!bus.wb_we) begin
                    egnt = 1; ewe = 1; ea = bus.dbg_addr; ed = bus.dbg_wdata;
                    lost = 0;
                end else begin
                    lost++;
                end
            end
            chk("m_rf_we", bus.rf_we, 32'(ewe && ea != 0));
            chk("m_rf_waddr", bus.rf_waddr, 32'(ea));
            chk("m_rf_wdata", bus.rf_wdata, ed);
            chk("m_gnt", bus.dbg_gnt, 32'(egnt));
            chk("m_rdsel", bus.dbg_rd_sel, 32'(esel));
            chk("m_stall", bus.pipe_stall, 32'(estall));
            chk("m_busy", bus.init_busy, 32'(ebusy));
            if (ewe && ea != 0) mrf[ea] = ed;
            rd_pend = rdg;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wb_we = we; bus.wb_addr = a; bus.wb_data = d;
    endtask

    task automatic dbg(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
    endtask

    // Counts busy cycles (bounded); returns at the first non-busy negedge.
    task automatic count_init(output int n, output int nwe, output logic [AW-1:0] first_addr);
        n = 0; nwe = 0; first_addr = '1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.init_busy) break;
            if (n == 0) first_addr = bus.rf_waddr;
            n++;
            if (bus.rf_we) nwe++;
        end
    endtask

    initial begin
        int n, nwe;
        logic [AW-1:0] fa;
        rst = 1'b1;
        wb(0, 0, 0);
        dbg(0, 0, 0, 0);
        repeat (3) tick();
        rst = 1'b0;
        count_init(n, nwe, fa);
        chk("init_cycles", n, 32);
        chk("init_writes", nwe, 31);
        chk("init_first_addr", fa, 0);
        chk("stall_after_init", bus.pipe_stall, 0);
        tick();

        wb(1, 3, 32'h3);
        @(negedge clk); chk("wb3_we", bus.rf_we, 1); chk("wb3_addr", bus.rf_waddr, 3); tick();

        wb(0, 0, 0); dbg(1, 1, 7, 32'h7);
        @(negedge clk);
        chk("dw7_gnt", bus.dbg_gnt, 1); chk("dw7_addr", bus.rf_waddr, 7);
        chk("dw7_data", bus.rf_wdata, 7); chk("dw7_we", bus.rf_we, 1);
        tick();

        dbg(1, 0, 3, 0);
        @(negedge clk);
        chk("rd3_gnt", bus.dbg_gnt, 1); chk("rd3_sel", bus.dbg_rd_sel, 1); chk("rd3_stall", bus.pipe_stall, 1);
        tick();
        dbg(1, 0, 0, 0);
        @(negedge clk);
        chk("rd3_valid", bus.dbg_rvalid, 1); chk("rd3_data", bus.dbg_rdata, 3); chk("rd0_gnt", bus.dbg_gnt, 1);
        tick();
        dbg(1, 0, 7, 0);
        @(negedge clk); chk("rd0_valid", bus.dbg_rvalid, 1); chk("rd0_data", bus.dbg_rdata, 0); tick();
        dbg(0, 0, 0, 0);
        @(negedge clk); chk("rd7_data", bus.dbg_rdata, 7); tick();
        @(negedge clk); chk("rvalid_pulse", bus.dbg_rvalid, 0); tick();

        wb(1, 5, 32'h55); dbg(1, 0, 5, 0);
        @(negedge clk); chk("rdw_gnt", bus.dbg_gnt, 1); chk("rdw_wb_we", bus.rf_we, 1); tick();
        wb(0, 0, 0); dbg(0, 0, 0, 0);
        @(negedge clk); chk("rdw_old", bus.dbg_rdata, 0); tick();
        dbg(1, 0, 5, 0);
        @(negedge clk); tick();
        dbg(0, 0, 0, 0);
        @(negedge clk); chk("rd5_new", bus.dbg_rdata, 32'h55); tick();

        wb(1, 0, 32'hFFFF_FFFF);
        @(negedge clk); chk("wb0_we", bus.rf_we, 0); tick();
        wb(0, 0, 0); dbg(1, 1, 0, 32'hFFFF_FFFF);
        @(negedge clk); chk("dw0_gnt", bus.dbg_gnt, 1); chk("dw0_we", bus.rf_we, 0); tick();

        dbg(1, 1, 9, 32'hA5A5_A5A5);
        for (int i = 0; i < MW; i++) begin
            wb(1, 10, 32'(i));
            @(negedge clk); chk("lose_stall", bus.pipe_stall, 0); chk("lose_gnt", bus.dbg_gnt, 0); tick();
        end
        wb(1, 11, 32'h99);
        @(negedge clk);
        chk("force_stall", bus.pipe_stall, 1); chk("force_gnt", bus.dbg_gnt, 0); chk("force_wb", bus.rf_waddr, 11);
        tick();
        wb(0, 0, 0);
        @(negedge clk);
        chk("force_grant", bus.dbg_gnt, 1); chk("force_addr", bus.rf_waddr, 9);
        chk("force_data", bus.rf_wdata, 32'hA5A5_A5A5); chk("force_we", bus.rf_we, 1);
        tick();
        dbg(0, 0, 0, 0);
        @(negedge clk); chk("release_stall", bus.pipe_stall, 0); tick();

        dbg(1, 1, 12, 32'h77);
        for (int i = 0; i < MW; i++) begin
            wb(1, 13, 32'(i));
            @(negedge clk); tick();
        end
        wb(1, 13, 32'h42);
        @(negedge clk); chk("force2_stall", bus.pipe_stall, 1); tick();
        rst = 1'b1;
        @(negedge clk); chk("rstf_gnt", bus.dbg_gnt, 0); chk("rstf_busy", bus.init_busy, 1); tick();
        wb(0, 0, 0);
        @(negedge clk); tick();
        rst = 1'b0;
        count_init(n, nwe, fa);
        chk("reinit_cycles", n, 32);
        chk("reinit_writes", nwe, 31);
        chk("reinit_first_addr", fa, 0);
        chk("post_init_gnt", bus.dbg_gnt, 1);
        chk("post_init_addr", bus.rf_waddr, 12);
        tick();
        dbg(1, 0, 12, 0);
        @(negedge clk); tick();
        dbg(0, 0, 0, 0);
        @(negedge clk); chk("rd12_data", bus.dbg_rdata, 32'h77); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
